prime_ctrl: RTL and testbench

//  Control FSM for the trial-division primality datapath. Drives the load strobes of the
//  n/rem/div/res register file and tests whether n is prime.

---
 rtl/prime_ctrl_if.sv | 30 +++
 rtl/prime_ctrl.sv | 112 +++++++++++
 tb/tb_prime_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prime_ctrl_if.sv
// Bundle between the primality controller and its n/rem/div/res register file.
// The controller takes the master side; the register file / host takes the slave side.
interface prime_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] n;
  logic [W-1:0] rem;
  logic [W-1:0] div;
  logic         res;
  logic [W-1:0] remi;
  logic         remld;
  logic [W-1:0] divi;
  logic         divld;
  logic         resi;
  logic         resld;
  logic         busy;
  logic         done;
  logic         prime;

  modport master (
    input  start, n, rem, div, res,
    output remi, remld, divi, divld, resi, resld, busy, done, prime
  );

  modport slave (
    output start, n, rem, div, res,
    input  remi, remld, divi, divld, resi, resld, busy, done, prime
  );
endinterface

// File: rtl/prime_ctrl.sv
// Trial-division primality controller: Mealy strobes into the register file,
// remainders by repeated subtraction, divisors from 2 while div*div <= n.
module prime_ctrl #(
  parameter int W = 16
) (
  input logic          clk,
  input logic          rst,
  prime_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    SUB,
    TEST,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;
  logic   prime_q;

  logic [2*W-1:0] div_wide;
  logic [2*W-1:0] n_wide;
  logic [2*W-1:0] sq;

  // Full-width square: div reaches 2^(W/2), whose square does not fit in W bits.
  assign div_wide = {{W{1'b0}}, bus.div};
  assign n_wide   = {{W{1'b0}}, bus.n};
  assign sq       = div_wide * div_wide;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no branch leaves an output unassigned and no latch is inferred.
    state_nx  = state;
    bus.remi  = '0;
    bus.remld = 1'b0;
    bus.divi  = '0;
    bus.divld = 1'b0;
    bus.resi  = 1'b0;
    bus.resld = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = INIT;
      end
      INIT: begin
        bus.divld = 1'b1;
        bus.divi  = W'(2);
        bus.resld = 1'b1;
        bus.resi  = (bus.n >= W'(2));
        state_nx  = CHECK;
      end
      CHECK: begin
        if (!bus.res || (sq > n_wide)) begin
          state_nx = DONE;
        end else begin
          bus.remld = 1'b1;
          bus.remi  = bus.n;
          state_nx  = SUB;
        end
      end
      SUB: begin
        if (bus.rem >= bus.div) begin
          bus.remld = 1'b1;
          bus.remi  = bus.rem - bus.div;
        end else begin
          state_nx = TEST;
        end
      end
      TEST: begin
        if (bus.rem == '0) begin
          bus.resld = 1'b1;
          bus.resi  = 1'b0;
          state_nx  = DONE;
        end else begin
          bus.divld = 1'b1;
          bus.divi  = bus.div + W'(1);
          state_nx  = CHECK;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Capture the result bit as it will stand after this edge, since TEST clears res on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_q <= 1'b0;
    end else if ((state != DONE) && (state_nx == DONE)) begin
      prime_q <= bus.resld ? bus.resi : bus.res;
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.prime = prime_q;

endmodule

// File: tb/tb_prime_ctrl.sv
// Bench for prime_ctrl: models the register file, compares against plain trial division
// with an edge-count formula, and covers reset, start-while-busy and wide-divisor corners.
module tb_prime_ctrl;

  localparam int W = 16;

  logic clk;
  logic rst;

  prime_ctrl_if #(.W(W)) bus ();

  prime_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Register file; ff_en substitutes the INIT divisor load to jump to a chosen divisor.
  logic         ff_en;
  logic [W-1:0] ff_div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rem <= '0;
      bus.div <= '0;
      bus.res <= 1'b0;
    end else begin
      if (bus.remld) bus.rem <= bus.remi;
      if (bus.divld) bus.div <= (ff_en && bus.divi == W'(2)) ? ff_div : bus.divi;
      if (bus.resld) bus.res <= bus.resi;
    end
  end

  int remld_cnt = 0;
  int done_cnt  = 0;
  int wrap_cnt  = 0;
  int max_divi  = 0;

  always @(negedge clk) begin
    if (bus.remld) remld_cnt++;
    if (bus.done) done_cnt++;
    if (bus.divld && bus.divi == '0) wrap_cnt++;
    if (bus.divld && int'(bus.divi) > max_divi) max_divi = int'(bus.divi);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: trial division from divisor d0; lat counts edges from the start-sampling
  // edge (inclusive) to the edge entering DONE, one CHECK/SUB/TEST pass per divisor tried.
  function automatic void model(input int n, input int d0, output bit pr, output int lat,
                                output int dv);
    int d;
    bit r;
    bit hit;
    d   = d0;
    r   = (n >= 2);
    hit = 1'b0;
    lat = 2;
    while (r && d * d <= n) begin
      lat += (n / d) + 3;
      if (n % d == 0) begin
        r   = 1'b0;
        hit = 1'b1;
      end else begin
        d++;
      end
    end
    if (!hit) lat += 1;
    pr = r;
    dv = d;
  endfunction

  task automatic run(input logic [W-1:0] nv, output int lat, output bit ok);
    @(negedge clk);
    bus.n     = nv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] nv, input int d0,
                               input int hand_lat);
    int  lat, exp_lat, exp_dv;
    bit  ok, exp_pr;
    model(int'(nv), d0, exp_pr, exp_lat, exp_dv);
    if (hand_lat != 0) exp_lat = hand_lat;
    run(nv, lat, ok);
    check({tag, " done seen"}, ok, 1);
    check({tag, " prime"}, bus.prime, exp_pr);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " div at done"}, bus.div, exp_dv);
    @(negedge clk);
    check({tag, " done width"}, bus.done, 0);
  endtask

  typedef struct {
    logic [W-1:0] n;
    bit           prime;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  lat, snap, exp_lat, exp_dv;
    bit  ok, exp_pr;
    logic [W-1:0] rn;

    vecs[0] = '{16'd0,  1'b0, 3};
    vecs[1] = '{16'd1,  1'b0, 3};
    vecs[2] = '{16'd2,  1'b1, 3};
    vecs[3] = '{16'd3,  1'b1, 3};
    vecs[4] = '{16'd4,  1'b0, 7};
    vecs[5] = '{16'd7,  1'b1, 9};
    vecs[6] = '{16'd49, 1'b0, 0};
    vecs[7] = '{16'd97, 1'b1, 0};

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.n     = '0;
    ff_en     = 1'b0;
    ff_div    = '0;
    #3;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset prime", bus.prime, 0);
    check("reset strobes", {bus.remld, bus.divld, bus.resld}, 0);
    check("reset remi", bus.remi, 0);
    check("reset divi", bus.divi, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      snap = remld_cnt;
      run(vecs[i].n, lat, ok);
      check($sformatf("vec n=%0d done seen", vecs[i].n), ok, 1);
      check($sformatf("vec n=%0d prime", vecs[i].n), bus.prime, vecs[i].prime);
      check($sformatf("vec n=%0d busy in done", vecs[i].n), bus.busy, 1);
      model(int'(vecs[i].n), 2, exp_pr, exp_lat, exp_dv);
      check($sformatf("vec n=%0d latency", vecs[i].n), lat,
            (vecs[i].lat != 0) ? vecs[i].lat : exp_lat);
      @(negedge clk);
      check($sformatf("vec n=%0d done width", vecs[i].n), bus.done, 0);
      check($sformatf("vec n=%0d prime held", vecs[i].n), bus.prime, vecs[i].prime);
      if (vecs[i].n < 2) check($sformatf("vec n=%0d no remld", vecs[i].n), remld_cnt - snap, 0);
    end

    for (int i = 0; i < 20; i++) begin
      rn = W'($urandom_range(0, 300));
      snap = remld_cnt;
      run_and_check($sformatf("rand n=%0d", rn), rn, 2, 0);
      if (rn < 2) check($sformatf("rand n=%0d no remld", rn), remld_cnt - snap, 0);
    end

    // Jump straight to wide divisors for the largest 16-bit prime and for 65535.
    ff_en  = 1'b1;
    ff_div = W'(256);
    run_and_check("n=65521 div=256", 16'd65521, 256, 3);
    ff_div = W'(255);
    run_and_check("n=65521 div=255", 16'd65521, 255, 2 + (65521 / 255) + 3 + 1);
    check("max div observed", max_divi, 256);
    check("div wrap count", wrap_cnt, 0);
    ff_div = W'(3);
    run_and_check("n=65535 div=3", 16'd65535, 3, 0);
    ff_en = 1'b0;

    // Async reset in the middle of SUB.
    run_and_check("pre-reset n=7", 16'd7, 2, 0);
    @(negedge clk);
    bus.n     = 16'd100;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("in SUB before reset", bus.remld, 1);
    #2 rst = 1'b0;
    #1;
    check("mid reset busy", bus.busy, 0);
    check("mid reset strobes", {bus.remld, bus.divld, bus.resld}, 0);
    check("mid reset prime", bus.prime, 0);
    check("mid reset remi/divi", {bus.remi, bus.divi}, 0);
    @(negedge clk);
    rst = 1'b1;
    run_and_check("post-reset n=9", 16'd9, 2, 0);

    // start held high through DONE relaunches after one IDLE cycle.
    @(negedge clk);
    bus.n     = 16'd2;
    bus.start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    check("held start first done", ok, 1);
    @(negedge clk);
    check("held start idle gap", bus.busy, 0);
    @(negedge clk);
    check("held start relaunch", bus.busy, 1);
    bus.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    check("held start second done", ok, 1);
    check("held start prime", bus.prime, 1);

    // start pulsed again while busy on n=13 is ignored.
    repeat (2) @(negedge clk);
    snap = done_cnt;
    bus.n     = 16'd13;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    repeat (8) @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("busy start done pulses", done_cnt - snap, 1);
    check("busy start prime", bus.prime, 1);
    check("busy start idle", bus.busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
